// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Consumer end of the program-counter interface in the BIP-2 datapath.
//   The block samples the PC and issues one program-memory read over a
//   req/ack handshake. It holds the returned instruction, split into
//   opcode and operand, until the control unit accepts it. On acceptance
//   it pulses pc_enable_o for one cycle so the PC register advances.
//   flush_i discards whatever is in flight or held. This supports
//   branches and jumps, where the control unit loads the target PC itself.
//
//   Per-instruction sequence: IDLE -> REQ -> HOLD -> IDLE.
//   With a zero-wait memory and instr_ready_i held high, one instruction
//   takes 3 cycles.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a counter runs while the block is in REQ. If TIMEOUT_CYC
//   cycles pass without mem_ack_i, the block:
//     - sets the sticky fetch_err_o flag,
//     - drops the request,
//     - returns to IDLE, then retries at the current pc_i.
//   When undefined, fetch_err_o is tied low and REQ waits indefinitely.
//
// Ports:
//   clock_i        in   1       system clock, rising edge
//   reset_n_i      in   1       asynchronous active-low reset
//   pc_i           in   ADDR_W  current PC register value
//   pc_enable_o    out  1       one-cycle pulse, the PC loads its next value
//   mem_req_o      out  1       program memory read request
//   mem_addr_o     out  ADDR_W  read address, stable while mem_req_o is high
//   mem_ack_i      in   1       memory returns data this cycle
//   mem_data_i     in   DATA_W  read data, valid with mem_ack_i
//   instr_valid_o  out  1       instruction held and presented
//   instr_ready_i  in   1       control unit accepts the instruction
//   opcode_o       out  OPC_W   held opcode (undecoded)
//   operand_o      out  ADDR_W  held operand (zero-extended/truncated)
//   flush_i        in   1       discard in-flight or held instruction
//   fetch_err_o    out  1       sticky timeout flag (feature only)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int OPC_W       = 5,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_enable_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [ADDR_W-1:0] operand_o,
  input  logic              flush_i,
  output logic              fetch_err_o
);

  // Width of the operand field inside the instruction word.
  localparam int OPR_W = DATA_W - OPC_W;

  // Reject nonsensical parameter sets at elaboration time.
  if (OPC_W < 1 || OPC_W >= DATA_W || ADDR_W < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("instr_fetch: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_reg,     state_next;
  logic              mem_req_reg,   mem_req_next;
  logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
  logic              valid_reg,     valid_next;
  logic [OPC_W-1:0]  opcode_reg,    opcode_next;
  logic [ADDR_W-1:0] operand_reg,   operand_next;
  logic              pc_enable_reg, pc_enable_next;

  // Operand field fitted to the PC width.
  logic [ADDR_W-1:0] operand_fit;
  logic [OPC_W-1:0]  opcode_fit;

  // True on the REQ cycle where the wait budget runs out.
  logic              timeout_hit;

  assign opcode_fit = mem_data_i[DATA_W-1 -: OPC_W];

  // The operand field is either truncated or zero-extended to the PC width.
  if (OPR_W >= ADDR_W) begin : g_opr_trunc
    assign operand_fit = mem_data_i[ADDR_W-1:0];
  end else begin : g_opr_zext
    assign operand_fit = {{(ADDR_W - OPR_W){1'b0}}, mem_data_i[OPR_W-1:0]};
  end

`ifdef FETCH_TIMEOUT_EN
  // The counter must hold values up to TIMEOUT_CYC-1, using at least 4 bits.
  localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 4) ? $clog2(TIMEOUT_CYC) : 4;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  // The counter is 0 on entry to REQ and counts one per REQ cycle without ack.
  // Reaching TIMEOUT_CYC-1 means this is the TIMEOUT_CYC-th unanswered cycle.
  assign timeout_hit = (state_reg == ST_REQ) && !mem_ack_i &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_next = '0;
    err_next = err_reg;
    // Flush outranks the timeout: on flush the counter clears and the flag holds.
    if (!flush_i && (state_reg == ST_REQ) && !mem_ack_i) begin
      if (timeout_hit) begin
        err_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign fetch_err_o = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  // Next-state and output logic. Every register holds its value unless a
  // transition below changes it. pc_enable is a pulse, so it defaults to 0.
  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    valid_next     = valid_reg;
    opcode_next    = opcode_reg;
    operand_next   = operand_reg;
    pc_enable_next = 1'b0;

    if (flush_i) begin
      // Drop any ack or acceptance landing this cycle. The PC is redirected
      // by the control unit, so no pc_enable pulse is issued.
      state_next   = ST_IDLE;
      mem_req_next = 1'b0;
      valid_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          mem_addr_next = pc_i;
          mem_req_next  = 1'b1;
          state_next    = ST_REQ;
        end

        ST_REQ: begin
          if (mem_ack_i) begin
            opcode_next  = opcode_fit;
            operand_next = operand_fit;
            mem_req_next = 1'b0;
            valid_next   = 1'b1;
            state_next   = ST_HOLD;
          end else if (timeout_hit) begin
            // Abandon the request. IDLE then retries at whatever pc_i is.
            mem_req_next = 1'b0;
            state_next   = ST_IDLE;
          end
        end

        ST_HOLD: begin
          // mem_ack_i is deliberately ignored here: only one request may be
          // outstanding.
          if (valid_reg && instr_ready_i) begin
            valid_next     = 1'b0;
            pc_enable_next = 1'b1;
            state_next     = ST_IDLE;
          end
        end

        default: begin
          state_next   = ST_IDLE;
          mem_req_next = 1'b0;
          valid_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg     <= ST_IDLE;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      valid_reg     <= 1'b0;
      opcode_reg    <= '0;
      operand_reg   <= '0;
      pc_enable_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
      valid_reg     <= valid_next;
      opcode_reg    <= opcode_next;
      operand_reg   <= operand_next;
      pc_enable_reg <= pc_enable_next;
    end
  end

  assign mem_req_o     = mem_req_reg;
  assign mem_addr_o    = mem_addr_reg;
  assign instr_valid_o = valid_reg;
  assign opcode_o      = opcode_reg;
  assign operand_o     = operand_reg;
  assign pc_enable_o   = pc_enable_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch.
//
// Each fetch is described at transaction level by:
//   - pc, instruction word,
//   - number of memory wait cycles, number of backpressure cycles,
//   - an optional flush point.
// Expected outputs are derived from those parameters with plain arithmetic.
// The stimulus mixes directed cases with $urandom-chosen transactions.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 16;
  localparam int OPC_W       = 5;
  localparam int TIMEOUT_CYC = 15;

  logic              clock_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              pc_enable_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i = 1'b0;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic              instr_valid_o;
  logic              instr_ready_i = 1'b0;
  logic [OPC_W-1:0]  opcode_o;
  logic [ADDR_W-1:0] operand_o;
  logic              flush_i = 1'b0;
  logic              fetch_err_o;

  int   n_checks = 0;
  int   n_errors = 0;
  logic err_exp  = 1'b0;

  instr_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OPC_W(OPC_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .pc_i(pc_i),
    .pc_enable_o(pc_enable_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .opcode_o(opcode_o), .operand_o(operand_o), .flush_i(flush_i),
    .fetch_err_o(fetch_err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // One fetch starting with the DUT in IDLE. The DUT ends in IDLE.
  // mode: 0 = normal
  //       1 = flush on the ack edge (flush held one more cycle)
  //       2 = flush on the accept edge
  //       3 = flush on the last memory-wait edge (needs ack_wait >= 1)
  task automatic do_fetch(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] data,
                          input int ack_wait, input int rdy_wait, input int mode);
    logic [OPC_W-1:0]  opc_exp;
    logic [ADDR_W-1:0] opr_exp;
    opc_exp = OPC_W'(data / (2 ** (DATA_W - OPC_W)));
    opr_exp = ADDR_W'(data % (2 ** (DATA_W - OPC_W)));

    pc_i = pc; mem_ack_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b0;
    step();
    chk("req_issue",      32'(mem_req_o),     32'(1));
    chk("req_addr",       32'(mem_addr_o),    32'(pc));
    chk("pulse_one_cyc",  32'(pc_enable_o),   32'(0));
    chk("valid_in_req",   32'(instr_valid_o), 32'(0));
    chk("err_flag",       32'(fetch_err_o),   32'(err_exp));

    for (int k = 0; k < ack_wait; k++) begin
      pc_i          = ADDR_W'($urandom);
      mem_data_i    = DATA_W'($urandom);
      instr_ready_i = 1'($urandom);
      if (mode == 3 && k == ack_wait - 1) flush_i = 1'b1;
      step();
      if (mode == 3 && k == ack_wait - 1) begin
        flush_i = 1'b0;
        chk("flush_wait_req",   32'(mem_req_o),     32'(0));
        chk("flush_wait_valid", 32'(instr_valid_o), 32'(0));
        return;
      end
      chk("wait_req",         32'(mem_req_o),     32'(1));
      chk("wait_addr_stable", 32'(mem_addr_o),    32'(pc));
      chk("wait_no_valid",    32'(instr_valid_o), 32'(0));
    end

    mem_ack_i = 1'b1; mem_data_i = data; instr_ready_i = 1'($urandom);
    if (mode == 1) flush_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    if (mode == 1) begin
      chk("flush_ack_valid", 32'(instr_valid_o), 32'(0));
      chk("flush_ack_req",   32'(mem_req_o),     32'(0));
      chk("flush_ack_pulse", 32'(pc_enable_o),   32'(0));
      step();  // flush still high while idle: no new request may start
      flush_i = 1'b0;
      chk("flush_idle_req",  32'(mem_req_o),     32'(0));
      chk("flush_keep_err",  32'(fetch_err_o),   32'(err_exp));
      return;
    end
    chk("ack_valid",    32'(instr_valid_o), 32'(1));
    chk("ack_req_drop", 32'(mem_req_o),     32'(0));
    chk("ack_opcode",   32'(opcode_o),      32'(opc_exp));
    chk("ack_operand",  32'(operand_o),     32'(opr_exp));
    chk("ack_no_pulse", 32'(pc_enable_o),   32'(0));

    for (int k = 0; k < rdy_wait; k++) begin
      instr_ready_i = 1'b0;
      mem_ack_i     = 1'($urandom);  // stray acks must be ignored
      mem_data_i    = DATA_W'($urandom);
      pc_i          = ADDR_W'($urandom);
      step();
      chk("bp_valid",    32'(instr_valid_o), 32'(1));
      chk("bp_opcode",   32'(opcode_o),      32'(opc_exp));
      chk("bp_operand",  32'(operand_o),     32'(opr_exp));
      chk("bp_no_req",   32'(mem_req_o),     32'(0));
      chk("bp_no_pulse", 32'(pc_enable_o),   32'(0));
    end

    mem_ack_i = 1'b0; instr_ready_i = 1'b1;
    if (mode == 2) flush_i = 1'b1;
    step();
    instr_ready_i = 1'b0; flush_i = 1'b0;
    chk("acc_valid_drop", 32'(instr_valid_o), 32'(0));
    chk("acc_pulse",      32'(pc_enable_o),   32'((mode == 2) ? 0 : 1));
    chk("acc_no_req",     32'(mem_req_o),     32'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(mem_req_o),     32'(0));
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'(0));
    chk({tag, "_pulse"}, 32'(pc_enable_o),   32'(0));
    chk({tag, "_err"},   32'(fetch_err_o),   32'(0));
    chk({tag, "_addr"},  32'(mem_addr_o),    32'(0));
    chk({tag, "_opc"},   32'(opcode_o),      32'(0));
    chk({tag, "_opr"},   32'(operand_o),     32'(0));
  endtask

  initial begin
    int aw, rw, md;

    // Power-on reset.
    step(); step();
    chk_reset_outputs("por");

    // Release reset and enter REQ at pc 00A, then reset asynchronously mid-REQ.
    reset_n_i = 1'b1; pc_i = 11'h00A;
    step();
    chk("first_req",  32'(mem_req_o),  32'(1));
    chk("first_addr", 32'(mem_addr_o), 32'(11'h00A));
    step();
    #3 reset_n_i = 1'b0;
    #1 chk_reset_outputs("async_rst");
    step();
    reset_n_i = 1'b1;
    step();
    chk("rel_req",  32'(mem_req_o),  32'(1));
    chk("rel_addr", 32'(mem_addr_o), 32'(11'h00A));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_req_drop", 32'(mem_req_o), 32'(0));

    // Directed fetches.
    do_fetch(11'h00A, 16'h280E, 0, 0, 0);  // zero-wait, opcode 05 operand 00E
    do_fetch(11'h123, 16'hFFFF, 4, 0, 0);  // four memory wait states
    do_fetch(11'h7FF, 16'h0801, 0, 5, 0);  // five cycles of backpressure
    do_fetch(11'h00A, 16'h1234, 0, 0, 1);  // flush on the ack edge
    do_fetch(11'h00E, 16'hA5A5, 0, 0, 0);  // refetch from the branch target
    do_fetch(11'h055, 16'h5A5A, 2, 3, 2);  // flush on the accept edge
    do_fetch(11'h0AA, 16'h0000, 3, 0, 3);  // flush during the memory wait
    do_fetch(11'h000, 16'hF800, 1, 1, 0);

    // Long memory stall.
    pc_i = 11'h321;
    step();
    chk("stall_req", 32'(mem_req_o), 32'(1));
`ifdef FETCH_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      step();
      if (k < TIMEOUT_CYC) begin
        chk("to_wait_req", 32'(mem_req_o),   32'(1));
        chk("to_wait_err", 32'(fetch_err_o), 32'(0));
      end else begin
        chk("to_req_drop", 32'(mem_req_o),   32'(0));
        chk("to_err_set",  32'(fetch_err_o), 32'(1));
      end
    end
    err_exp = 1'b1;
    pc_i = 11'h456;
    step();
    chk("to_retry_req",  32'(mem_req_o),   32'(1));
    chk("to_retry_addr", 32'(mem_addr_o),  32'(11'h456));
    chk("to_sticky",     32'(fetch_err_o), 32'(1));
`else
    for (int k = 0; k < 20; k++) begin
      pc_i = ADDR_W'($urandom);
      step();
      chk("stall_req_hold", 32'(mem_req_o),   32'(1));
      chk("stall_addr",     32'(mem_addr_o),  32'(11'h321));
      chk("stall_no_err",   32'(fetch_err_o), 32'(0));
    end
`endif
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("stall_flush_err", 32'(fetch_err_o), 32'(err_exp));

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      aw = int'($urandom_range(0, 6));
      rw = int'($urandom_range(0, 4));
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (md == 3 && aw == 0) aw = 1;
      do_fetch(ADDR_W'($urandom), DATA_W'($urandom), aw, rw, md);
    end

    // Final reset clears everything, including a sticky error.
    #2 reset_n_i = 1'b0;
    #1 chk_reset_outputs("final_rst");
    step();
    reset_n_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the program-counter interface in the BIP-2 datapath.
- Samples the 11-bit PC value and issues a read to program memory over a req/ack handshake.
- Holds the returned 16-bit instruction, split into a 5-bit opcode and an 11-bit operand, until the control unit accepts it.
- On acceptance, pulses the PC enable so the PC register advances. Supports flush on branch/jump.

Parameters:
- ADDR_W, 11, program address width (matches the PC width).
- DATA_W, 16, instruction width.
- OPC_W, 5, opcode field width (instruction bits [DATA_W-1 -: OPC_W]); operand = low DATA_W-OPC_W bits.
- TIMEOUT_CYC, 15, maximum wait for mem_ack_i (used only with the optional feature).

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- pc_i  in  ADDR_W  current PC register value.
- pc_enable_o  out  1  one-cycle pulse; the PC loads its next value.
- mem_req_o  out  1  program memory read request.
- mem_addr_o  out  ADDR_W  read address, stable while mem_req_o is high.
- mem_ack_i  in  1  memory returns data this cycle.
- mem_data_i  in  DATA_W  read data, valid when mem_ack_i is high.
- instr_valid_o  out  1  instruction held and presented.
- instr_ready_i  in  1  control unit accepts the instruction.
- opcode_o  out  OPC_W  held opcode.
- operand_o  out  ADDR_W  held operand.
- flush_i  in  1  discard the in-flight or held instruction.
- fetch_err_o  out  1  sticky timeout flag (feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - pc_enable_o, mem_req_o, instr_valid_o and fetch_err_o = 0.
  - mem_addr_o, opcode_o and operand_o = 0.
  - Reset asserted mid-transaction abandons the transaction immediately. No pulse is issued.
- IDLE:
  - Next edge: mem_addr_o <= pc_i, mem_req_o <= 1, go to REQ.
  - One idle cycle is inserted after reset, flush and acceptance so the PC update is visible before sampling.
- REQ:
  - mem_req_o and mem_addr_o are held stable until the edge where mem_ack_i = 1.
  - On that edge: capture mem_data_i into opcode_o/operand_o, mem_req_o <= 0, instr_valid_o <= 1, go to HOLD.
- HOLD:
  - opcode_o, operand_o and instr_valid_o are held stable while instr_ready_i = 0.
  - On the edge where instr_valid_o & instr_ready_i: instr_valid_o <= 0, pc_enable_o <= 1 for exactly one cycle, go to IDLE.
- Latency with zero-wait memory (ack in the first REQ cycle):
  - req asserted 1 cycle after IDLE.
  - valid 1 cycle after ack.
  - Minimum 3 cycles per instruction when instr_ready_i is held high.
- Flush (highest priority after reset):
  - Applies in any state: go to IDLE; mem_req_o, instr_valid_o and pc_enable_o <= 0.
  - Data acked in the same cycle as flush is dropped.
  - An instruction accepted in the same cycle as flush is dropped with no pc_enable_o pulse. The control unit loads the branch target into the PC itself.
- Only one outstanding request at a time. mem_ack_i outside REQ is ignored.
- Operand is zero-extended/truncated to ADDR_W. Opcode is passed through undecoded.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit-or-wider counter runs while in REQ.
  - If TIMEOUT_CYC cycles pass without mem_ack_i: set fetch_err_o (sticky until reset), drop mem_req_o, go to IDLE, then retry at the current pc_i.
  - Flush clears the counter but not the flag.
- Undefined: no counter logic; fetch_err_o is tied to 0; REQ waits indefinitely.

Test Plan:
- Reset: drive reset_n_i low mid-REQ with pc_i=11'h00A -> all outputs 0 immediately. After release, mem_req_o=1 with mem_addr_o=11'h00A after 1 cycle.
- Zero-wait fetch: pc_i=11'h00A; ack same cycle with mem_data_i=16'h280E; instr_ready_i=1 -> opcode_o=5'h05, operand_o=11'h00E, valid for 1 cycle, then pc_enable_o pulses exactly once.
- Memory wait states: ack delayed 4 cycles -> mem_addr_o stays stable at pc_i for the whole wait; valid only after the ack.
- Backpressure: instr_ready_i held low for 5 cycles -> opcode/operand/valid unchanged, no pulse, no new request. Pulse occurs on the cycle after ready rises.
- Flush: flush_i asserted on the ack cycle -> data dropped, no valid, no pulse. Refetch issued from new pc_i=11'h00E.
- FETCH_TIMEOUT_EN: no ack for 15 cycles -> fetch_err_o=1 (sticky), request retried. Without the macro, fetch_err_o stays 0 and mem_req_o stays high.
